// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded ID fields, MEM/WB forwarding sources, pipeline
// control and the EX-side results (ALU operands, EX control, hazard stall).
//   master : pipeline control / ID side (drives ID fields, MEM/WB, stall, flush)
//   slave  : id_ex_stage (drives alu_a/alu_b/alu_op, ex_*, hz_stall)
interface id_ex_stage_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
);
  logic          stall;
  logic          flush;
  logic          id_valid;
  logic [RW-1:0] id_rs;
  logic [RW-1:0] id_rt;
  logic [RW-1:0] id_wdst;
  logic          id_use_rs;
  logic          id_use_rt;
  logic [DW-1:0] id_rs_data;
  logic [DW-1:0] id_rt_data;
  logic [15:0]   id_imm;
  logic [4:0]    id_shamt;
  logic [3:0]    id_alu_op;
  logic          id_alu_src;
  logic          id_shift_src;
  logic          id_sign_ext;
  logic          id_reg_write;
  logic          id_mem_read;
  logic          mem_reg_write;
  logic [RW-1:0] mem_wdst;
  logic [DW-1:0] mem_result;
  logic          wb_reg_write;
  logic [RW-1:0] wb_wdst;
  logic [DW-1:0] wb_result;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [3:0]    alu_op;
  logic          ex_valid;
  logic          ex_reg_write;
  logic          ex_mem_read;
  logic [RW-1:0] ex_wdst;
  logic [DW-1:0] ex_rt_fwd;
  logic          hz_stall;

  modport master (
    output stall, flush, id_valid, id_rs, id_rt, id_wdst, id_use_rs, id_use_rt,
           id_rs_data, id_rt_data, id_imm, id_shamt, id_alu_op, id_alu_src,
           id_shift_src, id_sign_ext, id_reg_write, id_mem_read,
           mem_reg_write, mem_wdst, mem_result, wb_reg_write, wb_wdst, wb_result,
    input  alu_a, alu_b, alu_op, ex_valid, ex_reg_write, ex_mem_read, ex_wdst,
           ex_rt_fwd, hz_stall
  );

  modport slave (
    input  stall, flush, id_valid, id_rs, id_rt, id_wdst, id_use_rs, id_use_rt,
           id_rs_data, id_rt_data, id_imm, id_shamt, id_alu_op, id_alu_src,
           id_shift_src, id_sign_ext, id_reg_write, id_mem_read,
           mem_reg_write, mem_wdst, mem_result, wb_reg_write, wb_wdst, wb_result,
    output alu_a, alu_b, alu_op, ex_valid, ex_reg_write, ex_mem_read, ex_wdst,
           ex_rt_fwd, hz_stall
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register and EX operand network for the 5-stage MIPS core.
// Captures decoded ID fields, builds ALU operands (register data, extended
// immediate, shamt, or forwarded MEM/WB results) and requests an ID hold on
// hazards while inserting a bubble into EX.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - synchronous active-high reset
//   bus  - id_ex_stage_if.slave: ID fields, MEM/WB sources, stall/flush in;
//          alu_a/alu_b/alu_op, ex_* control, ex_rt_fwd, hz_stall out
// Build option: define FWD_EN for the MEM/WB forwarding network. Without it,
// operands come from captured register data only and every RAW dependency on
// an in-flight producer (EX, MEM or WB) holds ID until the producer retires.
module id_ex_stage #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
) (
  input logic         clk,
  input logic         rst,
  id_ex_stage_if.slave bus
);

  logic          ex_valid_q;
  logic          ex_reg_write_q;
  logic          ex_mem_read_q;
  logic [RW-1:0] ex_wdst_q;
  logic [3:0]    ex_alu_op_q;
  logic          ex_alu_src_q;
  logic          ex_shift_src_q;
  logic          ex_sign_ext_q;
  logic [DW-1:0] ex_rs_data_q;
  logic [DW-1:0] ex_rt_data_q;
  logic [15:0]   ex_imm_q;
  logic [4:0]    ex_shamt_q;
`ifdef FWD_EN
  logic [RW-1:0] ex_rs_q;
  logic [RW-1:0] ex_rt_q;
`endif

  // True when the ID instruction reads register dst (register 0 never counts).
  function automatic logic id_reads(input logic use_rs, input logic [RW-1:0] rs,
                                    input logic use_rt, input logic [RW-1:0] rt,
                                    input logic [RW-1:0] dst);
    return (dst != '0) && ((use_rs && (rs == dst)) || (use_rt && (rt == dst)));
  endfunction

  logic load_use;
  logic raw_hazard;
  logic hazard;

  always_comb begin
    load_use = bus.id_valid && ex_valid_q && ex_mem_read_q &&
               id_reads(bus.id_use_rs, bus.id_rs, bus.id_use_rt, bus.id_rt, ex_wdst_q);
`ifdef FWD_EN
    raw_hazard = 1'b0;
`else
    raw_hazard = bus.id_valid && (
        (ex_reg_write_q &&
         id_reads(bus.id_use_rs, bus.id_rs, bus.id_use_rt, bus.id_rt, ex_wdst_q)) ||
        (bus.mem_reg_write &&
         id_reads(bus.id_use_rs, bus.id_rs, bus.id_use_rt, bus.id_rt, bus.mem_wdst)) ||
        (bus.wb_reg_write &&
         id_reads(bus.id_use_rs, bus.id_rs, bus.id_use_rt, bus.id_rt, bus.wb_wdst)));
`endif
    hazard = load_use || raw_hazard;
  end

  assign bus.hz_stall = hazard && !bus.flush && !bus.stall;

  logic [DW-1:0] fwd_rs;
  logic [DW-1:0] fwd_rt;
  logic [DW-1:0] ext_imm;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;

  always_comb begin
    fwd_rs = ex_rs_data_q;
    fwd_rt = ex_rt_data_q;
`ifdef FWD_EN
    // MEM is the younger producer, so it is checked before WB.
    if (bus.mem_reg_write && (bus.mem_wdst != '0) && (bus.mem_wdst == ex_rs_q)) begin
      fwd_rs = bus.mem_result;
    end else if (bus.wb_reg_write && (bus.wb_wdst != '0) && (bus.wb_wdst == ex_rs_q)) begin
      fwd_rs = bus.wb_result;
    end
    if (bus.mem_reg_write && (bus.mem_wdst != '0) && (bus.mem_wdst == ex_rt_q)) begin
      fwd_rt = bus.mem_result;
    end else if (bus.wb_reg_write && (bus.wb_wdst != '0) && (bus.wb_wdst == ex_rt_q)) begin
      fwd_rt = bus.wb_result;
    end
`endif
    ext_imm = ex_sign_ext_q ? {{(DW-16){ex_imm_q[15]}}, ex_imm_q}
                            : {{(DW-16){1'b0}}, ex_imm_q};
    op_a    = ex_shift_src_q ? {{(DW-5){1'b0}}, ex_shamt_q} : fwd_rs;
    op_b    = ex_alu_src_q ? ext_imm : fwd_rt;
  end

  // Operands are zeroed for a bubble so the ALU sees a clean NOP.
  assign bus.alu_a        = ex_valid_q ? op_a : '0;
  assign bus.alu_b        = ex_valid_q ? op_b : '0;
  assign bus.ex_rt_fwd    = ex_valid_q ? fwd_rt : '0;
  assign bus.alu_op       = ex_valid_q ? ex_alu_op_q : 4'd0;
  assign bus.ex_valid     = ex_valid_q;
  assign bus.ex_reg_write = ex_reg_write_q;
  assign bus.ex_mem_read  = ex_mem_read_q;
  assign bus.ex_wdst      = ex_wdst_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q     <= 1'b0;
      ex_reg_write_q <= 1'b0;
      ex_mem_read_q  <= 1'b0;
      ex_wdst_q      <= '0;
      ex_alu_op_q    <= 4'd0;
      ex_alu_src_q   <= 1'b0;
      ex_shift_src_q <= 1'b0;
      ex_sign_ext_q  <= 1'b0;
      ex_rs_data_q   <= '0;
      ex_rt_data_q   <= '0;
      ex_imm_q       <= '0;
      ex_shamt_q     <= '0;
`ifdef FWD_EN
      ex_rs_q        <= '0;
      ex_rt_q        <= '0;
`endif
    end else if (bus.stall) begin
      // Hold everything; a concurrent flush is re-issued by the controller.
    end else if (bus.flush || hazard) begin
      ex_valid_q     <= 1'b0;
      ex_reg_write_q <= 1'b0;
      ex_mem_read_q  <= 1'b0;
      ex_wdst_q      <= '0;
      ex_alu_op_q    <= 4'd0;
    end else begin
      ex_valid_q     <= bus.id_valid;
      // An empty ID slot must never look like a producer downstream.
      ex_reg_write_q <= bus.id_valid && bus.id_reg_write;
      ex_mem_read_q  <= bus.id_valid && bus.id_mem_read;
      ex_wdst_q      <= bus.id_wdst;
      ex_alu_op_q    <= bus.id_alu_op;
      ex_alu_src_q   <= bus.id_alu_src;
      ex_shift_src_q <= bus.id_shift_src;
      ex_sign_ext_q  <= bus.id_sign_ext;
      ex_rs_data_q   <= bus.id_rs_data;
      ex_rt_data_q   <= bus.id_rt_data;
      ex_imm_q       <= bus.id_imm;
      ex_shamt_q     <= bus.id_shamt;
`ifdef FWD_EN
      ex_rs_q        <= bus.id_rs;
      ex_rt_q        <= bus.id_rt;
`endif
    end
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register plus EX-stage operand network for the 5-stage MIPS core; drives the ALU's a, b and op inputs.
- Captures decoded fields from ID and selects ALU operands from register data, immediate, shamt, or forwarded results.
- Detects load-use hazards and requests an ID stall, inserting a bubble into EX.

Parameters:
- DW, 32, datapath width
- RW, 5, register index width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  external hold (memory wait); EX register keeps its contents
- flush  in  1  branch/jump squash; EX loads a bubble
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt, id_wdst  in  RW  source indices, destination index
- id_use_rs, id_use_rt  in  1  instruction reads rs / rt
- id_rs_data, id_rt_data  in  DW  register-file read data
- id_imm  in  16  immediate field
- id_shamt  in  5  shift amount
- id_alu_op  in  4  ALU opcode (0=NOP..9=LUI)
- id_alu_src  in  1  1: b = extended imm; 0: b = rt
- id_shift_src  in  1  1: a = zero-extended shamt; 0: a = rs
- id_sign_ext  in  1  1: sign-extend imm; 0: zero-extend
- id_reg_write, id_mem_read  in  1  write-back enable, load flag
- mem_reg_write  in  1  MEM-stage write enable
- mem_wdst  in  RW  MEM-stage destination
- mem_result  in  DW  MEM-stage ALU result
- wb_reg_write  in  1  WB-stage write enable
- wb_wdst  in  RW  WB-stage destination
- wb_result  in  DW  WB-stage data
- alu_a, alu_b  out  DW  ALU operands (combinational from EX register + forwarding)
- alu_op  out  4  ALU opcode
- ex_valid, ex_reg_write, ex_mem_read  out  1  EX-stage control
- ex_wdst  out  RW  EX-stage destination
- ex_rt_fwd  out  DW  forwarded rt value (store data)
- hz_stall  out  1  request ID/IF hold

Behaviour:
- Reset: all EX registers cleared. ex_valid=0, alu_op=0 (NOP), ex_wdst=0, ex_reg_write=0, ex_mem_read=0. alu_a=alu_b=ex_rt_fwd=0. hz_stall=0.
- Update priority each edge: rst > stall (hold) > flush (bubble) > hazard (bubble) > load ID fields. ex_valid <= id_valid on load.
- Bubble: ex_valid, ex_reg_write and ex_mem_read = 0; alu_op = 0; ex_wdst = 0.
- Hazard (load-use): id_valid & ex_valid & ex_mem_read & ex_wdst!=0 & ((id_use_rs & id_rs==ex_wdst) | (id_use_rt & id_rt==ex_wdst)).
  - hz_stall = hazard & ~flush & ~stall.
- Latency: one cycle from ID fields to alu_a, alu_b and alu_op.
- Immediate extension: sign-extend when ex_sign_ext=1, otherwise zero-extend; result is 32 bits.
- Forwarding (rs and rt independently): use mem_result if mem_reg_write & mem_wdst!=0 & mem_wdst==src; else wb_result under the same test on the wb_* signals; else the captured register data.
  - MEM beats WB when both match.
  - Register 0 is never forwarded.
- Operand selection:
  - alu_a = shift_src ? {27'b0, shamt} : fwd_rs.
  - alu_b = alu_src ? ext_imm : fwd_rt.
  - ex_rt_fwd = fwd_rt.
- When ex_valid=0: alu_a, alu_b and ex_rt_fwd are forced to 0, and alu_op=0.
- Simultaneous stall and flush: stall wins; flush is re-asserted by the controller.
- Reset during stall: the EX register clears.

Optional Feature:
- FWD_EN defined: forwarding network as above.
- FWD_EN undefined:
  - No forwarding muxes; operands come from captured register data only.
  - The hazard term additionally covers RAW matches against ex_wdst (any ex_reg_write), mem_wdst (mem_reg_write) and wb_wdst (wb_reg_write), excluding register 0.
  - ID stalls until the producer has left WB.

Test Plan:
- Reset, then id_valid=1, rs_data=5, rt_data=7, op=1, alu_src=0 -> next cycle alu_a=5, alu_b=7, alu_op=1, ex_valid=1.
- imm=16'hFFFC with sign_ext=1, alu_src=1 -> alu_b=32'hFFFFFFFC; with sign_ext=0 -> alu_b=32'h0000FFFC.
- EX holds rs=$3, mem_wdst=3, mem_result=0x11, wb_wdst=3, wb_result=0x22 -> alu_a=0x11; with mem_reg_write=0 -> alu_a=0x22; with rs=$0 -> alu_a=rs_data.
- EX holds lw to $4; ID instruction uses rt=$4 -> hz_stall=1, next cycle ex_valid=0 and alu_op=0, then the instruction is loaded once id_valid persists.
- stall=1 for 3 cycles with changing ID inputs -> EX outputs unchanged; stall=1 and flush=1 together -> hold; flush alone -> bubble.
- shift_src=1, shamt=4, op=6, rt=1 -> alu_a=4, alu_b=1; without FWD_EN, a RAW against mem_wdst -> hz_stall=1.
